// File: rtl/data_lsu.sv
// data_lsu: load/store unit between the core pipeline and a data bus with a
// request/grant phase and a separate read-response phase. One transaction is
// in flight at a time (IDLE -> REQ -> [WAIT] -> IDLE).
//
// Ports:
//   clk, rst_n              clock (rising edge), synchronous active-low reset
//   lsu_valid_in/_ready_o   pipeline request handshake (ready only in IDLE)
//   lsu_we_in, lsu_size_in  store flag, access size (00 byte, 01 half, 10 word)
//   lsu_unsigned_in         zero-extend loads instead of sign-extend
//   lsu_add_in, lsu_wdata_in, rd_in   byte address, store data, load tag
//   data_req_o .. data_rd_o bus request side, all driven from registers
//   data_gnt_in, data_rvalid_in, data_rdata_in, data_rd_in   bus response side
//   wb_valid_o, wb_rd_o, wb_data_o    one-cycle load writeback
//   err_o                   one-cycle pulse on misalignment (or timeout)
//
// Optional feature: define LSU_TIMEOUT_EN to abandon a transaction that sees
// no grant / no read response within 16 cycles of entering REQ or WAIT.
module data_lsu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        lsu_valid_in,
  output logic        lsu_ready_o,
  input  logic        lsu_we_in,
  input  logic [1:0]  lsu_size_in,
  input  logic        lsu_unsigned_in,
  input  logic [31:0] lsu_add_in,
  input  logic [31:0] lsu_wdata_in,
  input  logic [4:0]  rd_in,
  output logic        data_req_o,
  output logic        data_we_o,
  output logic [31:0] data_add_o,
  output logic [31:0] data_wdata_o,
  output logic [3:0]  data_be_o,
  output logic [4:0]  data_rd_o,
  input  logic        data_gnt_in,
  input  logic        data_rvalid_in,
  input  logic [31:0] data_rdata_in,
  input  logic [4:0]  data_rd_in,
  output logic        wb_valid_o,
  output logic [4:0]  wb_rd_o,
  output logic [31:0] wb_data_o,
  output logic        err_o
);

  typedef enum logic [1:0] {IDLE = 2'b00, REQ = 2'b01, WAIT = 2'b10} state_t;

  state_t      state_r;
  logic [1:0]  size_r;
  logic        unsigned_r;
  logic        misaligned_s;
  logic [31:0] load_data_s;
  logic        unused_s;
`ifdef LSU_TIMEOUT_EN
  logic [3:0]  tmo_cnt_r;
`endif

  // Byte-enable code for the bus; this is the bus's own encoding, not a lane mask.
  function automatic logic [3:0] calc_be(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] be;
    case (size)
      2'b00: begin
        case (off)
          2'b00:   be = 4'b1000;
          2'b01:   be = 4'b1001;
          2'b10:   be = 4'b1010;
          default: be = 4'b1100;
        endcase
      end
      2'b01:   be = off[1] ? 4'b0011 : 4'b0010;
      default: be = 4'b0001;
    endcase
    return be;
  endfunction

  // Store data is replicated so the addressed lane always carries it.
  function automatic logic [31:0] calc_wdata(input logic [1:0] size, input logic [31:0] wd);
    logic [31:0] r;
    case (size)
      2'b00:   r = {4{wd[7:0]}};
      2'b01:   r = {2{wd[15:0]}};
      default: r = wd;
    endcase
    return r;
  endfunction

  // Select the addressed lane of the read data and extend it to 32 bits.
  function automatic logic [31:0] load_extend(input logic [31:0] rdata, input logic [1:0] size,
                                              input logic [1:0] off, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'b00:   b = rdata[7:0];
      2'b01:   b = rdata[15:8];
      2'b10:   b = rdata[23:16];
      default: b = rdata[31:24];
    endcase
    h = off[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      2'b00:   r = uns ? {24'h000000, b} : {{24{b[7]}}, b};
      2'b01:   r = uns ? {16'h0000, h} : {{16{h[15]}}, h};
      default: r = rdata;
    endcase
    return r;
  endfunction

  // Size code 11 is handled as a word everywhere.
  assign misaligned_s = ((lsu_size_in == 2'b01) && lsu_add_in[0]) ||
                        (lsu_size_in[1] && (lsu_add_in[1:0] != 2'b00));
  assign load_data_s  = load_extend(data_rdata_in, size_r, data_add_o[1:0], unsigned_r);
  assign lsu_ready_o  = (state_r == IDLE);
  // The response tag is not needed: only one transaction can be outstanding.
  assign unused_s     = ^data_rd_in;

  // Transaction FSM; every bus and writeback output is a register written here.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      size_r       <= 2'b00;
      unsigned_r   <= 1'b0;
      data_req_o   <= 1'b0;
      data_we_o    <= 1'b0;
      data_add_o   <= 32'h0000_0000;
      data_wdata_o <= 32'h0000_0000;
      data_be_o    <= 4'b0000;
      data_rd_o    <= 5'd0;
      wb_valid_o   <= 1'b0;
      wb_rd_o      <= 5'd0;
      wb_data_o    <= 32'h0000_0000;
      err_o        <= 1'b0;
`ifdef LSU_TIMEOUT_EN
      tmo_cnt_r    <= 4'd0;
`endif
    end else begin
      wb_valid_o <= 1'b0;
      err_o      <= 1'b0;
      case (state_r)
        IDLE: begin
          if (lsu_valid_in) begin
            if (misaligned_s) begin
              err_o <= 1'b1;
            end else begin
              state_r      <= REQ;
              data_req_o   <= 1'b1;
              data_we_o    <= lsu_we_in;
              data_add_o   <= lsu_add_in;
              data_wdata_o <= calc_wdata(lsu_size_in, lsu_wdata_in);
              data_be_o    <= calc_be(lsu_size_in, lsu_add_in[1:0]);
              data_rd_o    <= rd_in;
              size_r       <= lsu_size_in;
              unsigned_r   <= lsu_unsigned_in;
`ifdef LSU_TIMEOUT_EN
              tmo_cnt_r    <= 4'd0;
`endif
            end
          end
        end
        REQ: begin
          if (data_gnt_in) begin
            data_req_o <= 1'b0;
            if (data_we_o) begin
              state_r <= IDLE;
            end else if (data_rvalid_in) begin
              // Grant and read data in the same cycle: skip WAIT.
              state_r    <= IDLE;
              wb_valid_o <= 1'b1;
              wb_rd_o    <= data_rd_o;
              wb_data_o  <= load_data_s;
            end else begin
              state_r <= WAIT;
`ifdef LSU_TIMEOUT_EN
              tmo_cnt_r <= 4'd0;
`endif
            end
          end
`ifdef LSU_TIMEOUT_EN
          else if (tmo_cnt_r == 4'd15) begin
            state_r    <= IDLE;
            data_req_o <= 1'b0;
            err_o      <= 1'b1;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + 4'd1;
          end
`endif
        end
        WAIT: begin
          if (data_rvalid_in) begin
            state_r    <= IDLE;
            wb_valid_o <= 1'b1;
            wb_rd_o    <= data_rd_o;
            wb_data_o  <= load_data_s;
          end
`ifdef LSU_TIMEOUT_EN
          else if (tmo_cnt_r == 4'd15) begin
            state_r <= IDLE;
            err_o   <= 1'b1;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + 4'd1;
          end
`endif
        end
        default: begin
          state_r    <= IDLE;
          data_req_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/data_lsu.md
DATA_LSU -- requirements
Module: data_lsu

Interface
REQ-001 The block SHALL have these ports: clk  in  1  sole clock, all state on rising edge.
REQ-002 rst_n  in  1  synchronous, active-low reset.
REQ-003 lsu_valid_in/lsu_ready_o  in/out  1/1  pipeline request handshake; lsu_we_in  in  1  1=store; lsu_size_in  in  2  00 byte, 01 half, 10 word; lsu_unsigned_in  in  1  zero-extend load.
REQ-004 lsu_add_in  in  32  byte address; lsu_wdata_in  in  32  store data (LSBs); rd_in  in  5  load destination tag.
REQ-005 data_req_o, data_we_o  out  1; data_add_o, data_wdata_o  out  32; data_be_o  out  4; data_rd_o  out  5: bus request side.
REQ-006 data_gnt_in, data_rvalid_in  in  1; data_rdata_in  in  32; data_rd_in  in  5: bus response side.
REQ-007 wb_valid_o  out  1; wb_rd_o  out  5; wb_data_o  out  32: load writeback; err_o  out  1: misaligned/timeout pulse.

Function
REQ-008 One transaction outstanding at a time; states IDLE, REQ, WAIT.
REQ-009 lsu_ready_o SHALL be 1 only in IDLE; request accepted on edge where lsu_valid_in && lsu_ready_o.
REQ-010 Accepted request SHALL be latched; bus outputs SHALL be driven from registers only, stable while data_req_o=1.
REQ-011 Misaligned (half at odd address, word with add[1:0]!=0): no bus request, err_o=1 for exactly the next cycle, stay IDLE.
REQ-012 Aligned request: IDLE->REQ; data_req_o=1 from the next cycle until the cycle data_gnt_in=1 is sampled.
REQ-013 data_add_o = latched byte address; data_rd_o = latched rd_in; data_we_o = lsu_we_in.
REQ-014 Byte enables SHALL be: word 0001; half offset 0 0010, offset 2 0011; byte offset 0/1/2/3 1000/1001/1010/1100.
REQ-015 data_wdata_o: byte in [7:0] replicated to all lanes; half replicated in both halves; word unchanged.
REQ-016 Store: REQ->IDLE on data_gnt_in; no writeback.
REQ-017 Load: REQ->WAIT on data_gnt_in without data_rvalid_in; REQ->IDLE directly if both sampled together.
REQ-018 WAIT->IDLE on data_rvalid_in; data_rvalid_in outside REQ/WAIT SHALL be ignored.
REQ-019 Read lane: byte k at data_rdata_in[8k+7:8k]; half at offset 0 [15:0], offset 2 [31:16].
REQ-020 wb_data_o SHALL be sign-extended, or zero-extended when latched lsu_unsigned_in=1; word passes through.
REQ-021 wb_valid_o SHALL pulse one cycle, the cycle after rvalid is sampled, with wb_rd_o = latched tag.
REQ-022 Minimum load latency: accept at edge 0, data_req_o high cycle 1, gnt+rvalid at edge 2, wb_valid_o high cycle 2..3 (one cycle).
REQ-023 lsu_valid_in while not ready SHALL be ignored (held by pipeline).

Reset
REQ-024 rst_n=0 at an edge SHALL force IDLE and clear data_req_o, data_we_o, data_be_o, wb_valid_o, err_o, timeout counter; data/address/tag outputs to 0.
REQ-025 Reset mid-transaction SHALL drop data_req_o at that edge; any later gnt/rvalid for it SHALL be ignored.

Configuration
REQ-026 Macro LSU_TIMEOUT_EN defined: 4-bit counter cleared on entering REQ or WAIT, increments each cycle there; at 15 without gnt/rvalid, return IDLE, drop data_req_o, err_o one-cycle pulse, no writeback.
REQ-027 LSU_TIMEOUT_EN undefined: no counter; REQ and WAIT wait indefinitely; err_o only for misalignment.

Verification
REQ-028 Word load add=0x10, gnt+rvalid cycle 1, rdata=0x8000_00FF -> be=0001, wb_valid one cycle, wb_data=0x8000_00FF, wb_rd=rd_in.
REQ-029 Signed byte load add=0x13, rdata=0x80AA_BBCC -> be=1100, wb_data=0xFFFF_FF80; unsigned -> 0x0000_0080.
REQ-030 Half store add=0x22 wdata=0x1234 with gnt delayed 3 cycles -> data_req_o high 4 cycles, be=0011, wdata=0x1234_1234, no wb_valid.
REQ-031 Word load add=0x21 -> no data_req_o, err_o one cycle, lsu_ready_o stays 1.
REQ-032 Load with gnt cycle 1, rvalid cycle 5 -> WAIT 4 cycles, lsu_ready_o=0 throughout, wb_valid cycle 6; reset in WAIT -> no wb_valid.
REQ-033 LSU_TIMEOUT_EN defined, gnt never asserted -> data_req_o drops after 16 cycles in REQ, err_o pulse, ready returns.
